alu_datapath: RTL and testbench
===============================

// Module: alu_datapath
// PURPOSE
//  Datapath that responds to the ALU controller's control vector {ld_1,ld_2,sel_1,op,en}.
//  Holds operand registers R1/R2, computes R1+R2 or R1-R2, and pushes results into a
//  DEPTH-entry result FIFO. The FIFO drains over a valid/ready handshake to downstream logic.
//  Sits between the controller and the result consumer.
// PARAMETERS
//  WIDTH  8  operand/result width in bits
//  DEPTH  4  result FIFO entries; power of two, >=2
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  rst_n         in   1      asynchronous active-low reset
//  ld_1          in   1      load R1 this cycle
//  ld_2          in   1      load R2 from data_in this cycle
//  sel_1         in   1      R1 source: 1=data_in, 0=ALU result
//  op            in   1      ALU op: 0=add, 1=subtract (R1-R2)
//  en            in   1      push current ALU result+flags into FIFO
//  data_in       in   WIDTH  operand input
//  res_data      out  WIDTH  FIFO head result
//  res_carry     out  1      head carry-out (add) / borrow (sub)
//  res_zero      out  1      head result == 0
//  res_valid     out  1      FIFO non-empty
//  res_ready     in   1      consumer accepts head when res_valid&res_ready
//  fifo_full     out  1      FIFO holds DEPTH entries
//  overflow      out  1      sticky: push attempted while full and not popping
//  overflow_clr  in   1      clears overflow
//  seq_err       out  1      control-sequence violation (see CONFIGURATION)
// BEHAVIOUR
//  Reset: R1=R2=0, FIFO empty, res_valid=0, fifo_full=0, overflow=0, seq_err=0,
//   res_data/res_carry/res_zero=0. Reset mid-operation discards all FIFO contents immediately.
//  ALU: combinational on current R1/R2. Width WIDTH+1 internally; res = low WIDTH bits,
//   carry = bit WIDTH (sub: borrow=1 when R1<R2). Wrap-around modulo 2^WIDTH.
//  Control sampled each posedge. All actions in a cycle use pre-edge register values:
//   ld_1 & en in the same cycle -> the pushed result uses the old R1, and R1 gets the new value.
//  ld_1&!sel_1 -> R1 <= ALU result (accumulate). ld_1&sel_1 -> R1 <= data_in.
//  Pop when res_valid&res_ready. Push when en.
//  Latency: push -> res_valid high the next cycle.
//  Full + push + pop same cycle: both proceed; count unchanged; no overflow.
//  Full + push, no pop: push dropped, FIFO unchanged, overflow<=1 next cycle.
//  Empty + pop: ignored (res_valid=0). Empty + push + ready: entry appears next cycle, not
//   bypassed.
//  overflow_clr and a new overflow event in the same cycle: set wins.
//  Pointers wrap modulo DEPTH. Count is 0..DEPTH, so full vs empty is unambiguous.
//  res_data/flags show the head entry while res_valid=1; value is don't-care when empty.
// CONFIGURATION
//  SEQ_CHECK_EN defined: a shadow FSM checks V={ld_1,ld_2,sel_1,op,en} per cycle.
//   C0: V=00000 stay; V=10100 -> C1; other -> error.
//   C1: V=01001 -> C2. C2: V=10100 -> C3. C3: V=10011 -> C0.
//   Any other V in C1..C3 -> error.
//   On error: seq_err<=1 (sticky until reset) and the FSM returns to C0.
//   Datapath actions still execute on error.
//  SEQ_CHECK_EN undefined: no shadow FSM; seq_err tied 0.
// TESTING
//  T1 ld_1,sel_1 din=5; ld_2 din=3; en op=0 -> next cycle res_valid=1, data=8, carry=0, zero=0
//  T2 R1=3,R2=5, en op=1 -> data=0xFE, carry(borrow)=1; R1=R2=7 op=1 -> data=0, zero=1
//  T3 res_ready=0, 5 pushes with DEPTH=4 -> fifo_full=1 after 4th; 5th dropped, overflow=1;
//     drain returns first 4 in order
//  T4 full FIFO, en and res_ready same cycle -> count stays 4, overflow stays 0,
//     new entry arrives last
//  T5 rst_n low mid-stream with 2 entries -> res_valid=0 asynchronously, R1=R2=0,
//     overflow=0
//  T6 (SEQ_CHECK_EN) drive 10100,01001,10100,10011 -> seq_err=0; then 10100,10100 -> seq_err=1

Source files
------------

// File: rtl/alu_datapath.sv
// Operand registers R1/R2, add/subtract ALU and a DEPTH-entry result FIFO drained by valid/ready.
// Optional control-sequence checker enabled by defining SEQ_CHECK_EN (seq_err tied low otherwise).
module alu_datapath #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_1,
  input  logic             ld_2,
  input  logic             sel_1,
  input  logic             op,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             fifo_full,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic             seq_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_r1;
  logic [WIDTH-1:0] r_r2;
  logic [WIDTH+1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  logic [WIDTH:0]   w_alu;
  logic             w_zero;
  logic             w_pop;
  logic             w_push;
  logic             w_ovf_evt;
  logic [AW:0]      w_count_nxt;
  logic [WIDTH+1:0] w_head;

  // ALU on the current operand registers; bit WIDTH is carry (add) or borrow (sub)
  always_comb begin
    w_alu = '0;
    if (op) begin
      w_alu = {1'b0, r_r1} - {1'b0, r_r2};
    end else begin
      w_alu = {1'b0, r_r1} + {1'b0, r_r2};
    end
  end

  assign w_zero    = (w_alu[WIDTH-1:0] == '0);
  assign w_pop     = (r_count != '0) && res_ready;
  assign w_push    = en && ((r_count != C_FULL_CNT) || w_pop);
  assign w_ovf_evt = en && (r_count == C_FULL_CNT) && !w_pop;

  // Occupancy update; simultaneous push and pop leaves it unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Operand registers, FIFO storage/pointers and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r1       <= '0;
      r_r2       <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (ld_1) begin
        r_r1 <= sel_1 ? data_in : w_alu[WIDTH-1:0];
      end
      if (ld_2) begin
        r_r2 <= data_in;
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_alu[WIDTH], w_zero, w_alu[WIDTH-1:0]};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      // A new overflow event takes priority over a clear in the same cycle
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign res_data  = w_head[WIDTH-1:0];
  assign res_zero  = w_head[WIDTH];
  assign res_carry = w_head[WIDTH+1];
  assign res_valid = (r_count != '0);
  assign fifo_full = (r_count == C_FULL_CNT);
  assign overflow  = r_overflow;

`ifdef SEQ_CHECK_EN
  typedef enum logic [1:0] {C0, C1, C2, C3} seq_state_t;

  seq_state_t r_seq_state;
  logic       r_seq_err;
  logic [4:0] w_v;

  assign w_v = {ld_1, ld_2, sel_1, op, en};

  // Shadow FSM: any vector off the expected load/load/add/accumulate path is sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_state <= C0;
      r_seq_err   <= 1'b0;
    end else begin
      case (r_seq_state)
        C0: begin
          if (w_v == 5'b00000) begin
            r_seq_state <= C0;
          end else if (w_v == 5'b10100) begin
            r_seq_state <= C1;
          end else begin
            r_seq_state <= C0;
            r_seq_err   <= 1'b1;
          end
        end
        C1: begin
          if (w_v == 5'b01001) begin
            r_seq_state <= C2;
          end else begin
            r_seq_state <= C0;
            r_seq_err   <= 1'b1;
          end
        end
        C2: begin
          if (w_v == 5'b10100) begin
            r_seq_state <= C3;
          end else begin
            r_seq_state <= C0;
            r_seq_err   <= 1'b1;
          end
        end
        C3: begin
          if (w_v == 5'b10011) begin
            r_seq_state <= C0;
          end else begin
            r_seq_state <= C0;
            r_seq_err   <= 1'b1;
          end
        end
        default: begin
          r_seq_state <= C0;
          r_seq_err   <= 1'b1;
        end
      endcase
    end
  end

  assign seq_err = r_seq_err;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// Randomized and directed bench for alu_datapath against a queue-based reference model.
module tb_alu_datapath;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld_1 = 1'b0, ld_2 = 1'b0, sel_1 = 1'b0, op = 1'b0, en = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] res_data;
  logic             res_carry, res_zero, res_valid, fifo_full, overflow, seq_err;
  logic             res_ready = 1'b0;
  logic             overflow_clr = 1'b0;

  alu_datapath #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ld_1(ld_1), .ld_2(ld_2), .sel_1(sel_1), .op(op), .en(en),
    .data_in(data_in), .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
    .res_valid(res_valid), .res_ready(res_ready), .fifo_full(fifo_full), .overflow(overflow),
    .overflow_clr(overflow_clr), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned data;
    bit          carry;
    bit          zero;
  } ent_t;

  int unsigned m_r1, m_r2;
  ent_t        m_q[$];
  bit          m_ovf;
  bit          m_seq_err;
  int          m_seq_pos;
  int unsigned m_pattern [4] = '{5'b10100, 5'b01001, 5'b10100, 5'b10011};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference step from the spec rules; uses pre-edge state for every action
  task automatic model_step();
    int unsigned res;
    bit          carry;
    bit          pop;
    int unsigned v;
    ent_t        e;
    if (op) begin
      res   = (m_r1 + 256 - m_r2) % 256;
      carry = (m_r1 < m_r2);
    end else begin
      res   = (m_r1 + m_r2) % 256;
      carry = (m_r1 + m_r2) > 255;
    end
    pop = (m_q.size() > 0) && res_ready;
    if (en && m_q.size() == DEPTH && !pop) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (en && (m_q.size() < DEPTH)) begin
      e.data = res; e.carry = carry; e.zero = (res == 0);
      m_q.push_back(e);
    end
    if (ld_1) m_r1 = sel_1 ? int'(data_in) : res;
    if (ld_2) m_r2 = int'(data_in);
    v = {ld_1, ld_2, sel_1, op, en};
    if (m_seq_pos == 0 && v == 0) m_seq_pos = 0;
    else if (v == m_pattern[m_seq_pos]) m_seq_pos = (m_seq_pos + 1) % 4;
    else begin
      m_seq_err = 1'b1;
      m_seq_pos = 0;
    end
  endtask

  task automatic check_outputs();
    bit exp_seq;
`ifdef SEQ_CHECK_EN
    exp_seq = m_seq_err;
`else
    exp_seq = 1'b0;
`endif
    check_val("res_valid", res_valid, m_q.size() != 0);
    check_val("fifo_full", fifo_full, m_q.size() == DEPTH);
    check_val("overflow", overflow, m_ovf);
    check_val("seq_err", seq_err, exp_seq);
    if (m_q.size() != 0) begin
      check_val("res_data", res_data, m_q[0].data);
      check_val("res_carry", res_carry, m_q[0].carry);
      check_val("res_zero", res_zero, m_q[0].zero);
    end
  endtask

  // One clock: drive at negedge, advance model, check after the edge
  task automatic cycle(input logic [4:0] v, input logic [7:0] din, input logic rdy, input logic clr);
    {ld_1, ld_2, sel_1, op, en} = v;
    data_in      = din;
    res_ready    = rdy;
    overflow_clr = clr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_valid", res_valid, 1'b0);
    check_val("rst_full", fifo_full, 1'b0);
    check_val("rst_ovf", overflow, 1'b0);
    check_val("rst_seq", seq_err, 1'b0);
    check_val("rst_data", res_data, 8'h00);
    m_r1 = 0; m_r2 = 0; m_q.delete(); m_ovf = 1'b0; m_seq_err = 1'b0; m_seq_pos = 0;
    {ld_1, ld_2, sel_1, op, en} = 5'b00000;
    res_ready = 1'b0; overflow_clr = 1'b0; data_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_r1 = 0; m_r2 = 0; m_ovf = 1'b0; m_seq_err = 1'b0; m_seq_pos = 0;
    @(negedge clk);
    do_reset();

`ifdef SEQ_CHECK_EN
    // T6: legal sequence keeps seq_err low, a repeated 10100 raises it
    cycle(5'b10100, 8'd2, 1'b1, 1'b0);
    cycle(5'b01001, 8'd1, 1'b1, 1'b0);
    cycle(5'b10100, 8'd4, 1'b1, 1'b0);
    cycle(5'b10011, 8'd0, 1'b1, 1'b0);
    check_val("t6_clean", seq_err, 1'b0);
    cycle(5'b10100, 8'd2, 1'b1, 1'b0);
    cycle(5'b10100, 8'd2, 1'b1, 1'b0);
    check_val("t6_err", seq_err, 1'b1);
    do_reset();
`endif

    // T1: 5 + 3
    cycle(5'b10100, 8'd5, 1'b0, 1'b0);
    cycle(5'b01000, 8'd3, 1'b0, 1'b0);
    cycle(5'b00001, 8'd0, 1'b0, 1'b0);
    check_val("t1_data", res_data, 8'd8);
    check_val("t1_carry", res_carry, 1'b0);
    check_val("t1_zero", res_zero, 1'b0);
    cycle(5'b00000, 8'd0, 1'b1, 1'b0);

    // T2: 3 - 5 borrows, 7 - 7 is zero
    cycle(5'b10100, 8'd3, 1'b0, 1'b0);
    cycle(5'b01000, 8'd5, 1'b0, 1'b0);
    cycle(5'b00011, 8'd0, 1'b0, 1'b0);
    check_val("t2_data", res_data, 8'hFE);
    check_val("t2_borrow", res_carry, 1'b1);
    cycle(5'b10100, 8'd7, 1'b1, 1'b0);
    cycle(5'b01000, 8'd7, 1'b0, 1'b0);
    cycle(5'b00011, 8'd0, 1'b0, 1'b0);
    check_val("t2_zdata", res_data, 8'h00);
    check_val("t2_zero", res_zero, 1'b1);
    cycle(5'b00000, 8'd0, 1'b1, 1'b0);

    // T3: five pushes without ready, then drain; accumulate so entries differ
    cycle(5'b10100, 8'd1, 1'b0, 1'b0);
    cycle(5'b01000, 8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(5'b10001, 8'd0, 1'b0, 1'b0);
      if (i == 3) check_val("t3_full", fifo_full, 1'b1);
    end
    check_val("t3_ovf", overflow, 1'b1);
    check_val("t3_head", res_data, 8'd2);

    // T4: full FIFO, push and pop together, then clear overflow and drain
    cycle(5'b00001, 8'd0, 1'b1, 1'b0);
    check_val("t4_full", fifo_full, 1'b1);
    cycle(5'b00000, 8'd0, 1'b0, 1'b1);
    check_val("t4_clr", overflow, 1'b0);
    for (int i = 0; i < 5; i++) cycle(5'b00000, 8'd0, 1'b1, 1'b0);
    check_val("t4_empty", res_valid, 1'b0);

    // T5: reset with two entries held, then confirm R1=R2=0 by pushing 0+0
    cycle(5'b10100, 8'd9, 1'b0, 1'b0);
    cycle(5'b00001, 8'd0, 1'b0, 1'b0);
    cycle(5'b00001, 8'd0, 1'b0, 1'b0);
    do_reset();
    cycle(5'b00001, 8'd0, 1'b0, 1'b0);
    check_val("t5_data", res_data, 8'h00);
    check_val("t5_zero", res_zero, 1'b1);
    cycle(5'b00000, 8'd0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] v;
      v = 5'($urandom_range(0, 31));
      v[0] = ($urandom_range(0, 99) < 55);
      cycle(v, 8'($urandom), ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 8));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
